calci_op_sequencer: RTL and testbench
=====================================

Name: calci_op_sequencer

Overview:
- Upstream front-end for the combinational 2-bit calculator core (a1:a0, b1:b0, select {s1,s0}; 4-bit result y3..y0 plus flag yrep).
- Collects operand A, operand B and the select code as three beats on a narrow valid/ready input stream.
- Drives the collected values as stable registered inputs to the core, waits a settle interval, then captures y and yrep.
- Presents the captured result on a valid/ready output stream. Converts the core's free-running combinational use into a transaction-per-operation interface.

Parameters:
- SETTLE_CYCLES, 1, cycles calc_* are held stable before the result is captured; legal range 1..15.
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- clr  in  1  synchronous soft abort; returns the FSM to GET_A.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  2  beat payload: A, then B, then select {s1,s0}.
- calc_a  out  2  to core a1:a0.
- calc_b  out  2  to core b1:b0.
- calc_sel  out  2  to core {s1,s0}.
- calc_y  in  4  from core y3..y0.
- calc_yrep  in  1  from core yrep.
- res_valid  out  1  captured result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  4  captured calc_y.
- res_flag  out  1  captured calc_yrep.
- res_sel  out  2  select code that produced the result.
- res_xerr  out  1  captured calc_y/calc_yrep contained X/Z (sim) or in_data beat was non-binary; synthesis ties this to 0.
- op_count  out  CNT_W  completed (handshaken) results, wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst_n=0, async):
  - state=GET_A.
  - calc_a, calc_b, calc_sel = 0.
  - res_valid, res_data, res_flag, res_sel, res_xerr = 0.
  - op_count=0.
  - in_ready=0 while rst_n low; in_ready=1 from the first clk edge after release.
- States: GET_A, GET_B, GET_SEL, SETTLE, HOLD.
  - in_ready = 1 only in GET_A/GET_B/GET_SEL; it is a function of state only.
- Beat acceptance: in_valid & in_ready on a rising edge.
  - GET_A: calc_a<=in_data → GET_B.
  - GET_B: calc_b<=in_data → GET_SEL.
  - GET_SEL: calc_sel<=in_data, settle counter<=SETTLE_CYCLES-1 → SETTLE.
- calc_* change only on their own accepted beat. They hold through SETTLE and HOLD and after the result is consumed, until overwritten by the next transaction.
- SETTLE:
  - Counter decrements each cycle.
  - On the edge where counter==0: res_data<=calc_y, res_flag<=calc_yrep, res_sel<=calc_sel, res_valid<=1 → HOLD.
  - Latency with SETTLE_CYCLES=S: the select beat is accepted on edge k; res_valid is high after edge k+S.
- HOLD:
  - res_* are stable while res_valid=1 and res_ready=0.
  - On res_valid & res_ready: res_valid<=0, op_count<=op_count+1 → GET_A.
  - No combinational path from res_ready to in_ready; a new A beat is accepted no earlier than the cycle after the handshake.
- res_ready high while not in HOLD has no effect.
- clr:
  - clr=1 in any state: next state GET_A, res_valid<=0, settle counter cleared.
  - calc_* and op_count are unchanged.
  - clr has priority over a simultaneous beat or result handshake; neither is counted or accepted.
- op_count wraps from 2^CNT_W-1 to 0 without saturation.
- Reset asserted mid-transaction: immediate return to reset values; partial beats are discarded.
- X handling (sim): if in_data has X/Z on an accepted beat, it is stored as-is and a sticky per-transaction xerr bit is set. res_xerr = sticky | X detected on calc_y/calc_yrep at capture. The sticky bit clears on entry to GET_A.

Decomposition:
- Shared package calci_pkg:
  - state enum encoding (GET_A=0, GET_B=1, GET_SEL=2, SETTLE=3, HOLD=4).
  - select code constants SEL_00, SEL_01, SEL_10, SEL_11 matching the core's {s1,s0} encoding.
  - operand width constant OPW=2 and result width RESW=4.
- One sub-module: calci_settle_timer (load/decrement/zero-flag counter).
- The sequencer instantiates the calculator core only in an optional wrapper calci_op_top. The sequencer itself connects to the core purely through its calc_* ports.

Test Plan:
- Basic: beats A=2, B=1, sel=00; bench core model drives calc_y=4'b0011, yrep=0 → res_valid one cycle after SETTLE; res_data=3, res_flag=0, res_sel=00; op_count=1 after handshake.
- Backpressure: sel=11, A=1, B=3, model returns y=4'b0000, yrep=1; hold res_ready=0 for 5 cycles → res_* stable, in_ready=0 throughout; handshake → op_count increments by 1 and in_ready=1 the next cycle.
- Gapped input: in_valid toggled 1/0 between beats, with SETTLE_CYCLES=3 → calc_* update only on accepted beats; res_valid rises exactly 3 edges after the select beat is accepted.
- clr in GET_SEL together with in_valid=1 → select not latched, state GET_A, res_valid stays 0, op_count unchanged; clr while in HOLD with res_ready=1 → res_valid drops, op_count unchanged.
- Async reset asserted during SETTLE, mid-cycle → all outputs 0 immediately; after release, a clean transaction A=3, B=3, sel=01 completes normally.
- Wrap and X: CNT_W=2, run 4 transactions → op_count reads 1,2,3,0; a beat with in_data=2'bxx → res_xerr=1 on that result and 0 on the next clean one.

Source files
------------

// File: rtl/calci_pkg.sv
// Shared types and constants for the calculator-core front-end.
// Encodings here must match the core's {s1,s0} select decode.
package calci_pkg;

    localparam int OPW  = 2;
    localparam int RESW = 4;

    typedef enum logic [2:0] {
        GET_A   = 3'd0,
        GET_B   = 3'd1,
        GET_SEL = 3'd2,
        SETTLE  = 3'd3,
        HOLD    = 3'd4
    } state_e;

    localparam logic [1:0] SEL_00 = 2'b00;
    localparam logic [1:0] SEL_01 = 2'b01;
    localparam logic [1:0] SEL_10 = 2'b10;
    localparam logic [1:0] SEL_11 = 2'b11;

endpackage

// File: rtl/calci_settle_timer.sv
// Load/decrement down-counter with zero flag; load takes effect next edge.
// Latency 1 cycle from load to count; no backpressure, clr_i wins over load.
module calci_settle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/calci_op_sequencer.sv
// Collects A/B/select beats, holds them on the core, captures y after SETTLE_CYCLES.
// Result held under res_ready backpressure; input stalls until the result is taken.
module calci_op_sequencer
    import calci_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   in_data,
    output logic [OPW-1:0]   calc_a,
    output logic [OPW-1:0]   calc_b,
    output logic [1:0]       calc_sel,
    input  logic [RESW-1:0]  calc_y,
    input  logic             calc_yrep,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [RESW-1:0]  res_data,
    output logic             res_flag,
    output logic [1:0]       res_sel,
    output logic             res_xerr,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic             rdy_en_q;
    logic [OPW-1:0]   calc_a_q, calc_b_q;
    logic [1:0]       calc_sel_q;
    logic             res_valid_q, res_flag_q, res_xerr_q, xsticky_q;
    logic [RESW-1:0]  res_data_q;
    logic [1:0]       res_sel_q;
    logic [CNT_W-1:0] op_count_q;
    logic             beat_acc, capture, res_hs, tmr_zero;

    // rdy_en_q keeps in_ready low until the first edge after reset release.
    assign in_ready = rdy_en_q &&
                      (state_q == GET_A || state_q == GET_B || state_q == GET_SEL);
    assign beat_acc = in_valid && in_ready && !clr;
    assign capture  = (state_q == SETTLE) && tmr_zero && !clr;
    assign res_hs   = (state_q == HOLD) && res_valid_q && res_ready && !clr;

    calci_settle_timer #(.W(4)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (clr),
        .load_i     (beat_acc && (state_q == GET_SEL)),
        .load_val_i (SETTLE_LOAD),
        .dec_i      (state_q == SETTLE),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            GET_A:   if (beat_acc) state_d = GET_B;
            GET_B:   if (beat_acc) state_d = GET_SEL;
            GET_SEL: if (beat_acc) state_d = SETTLE;
            SETTLE:  if (capture)  state_d = HOLD;
            HOLD:    if (res_hs)   state_d = GET_A;
            default:               state_d = GET_A;
        endcase
        if (clr) state_d = GET_A;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= GET_A;
            rdy_en_q    <= 1'b0;
            calc_a_q    <= '0;
            calc_b_q    <= '0;
            calc_sel_q  <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_flag_q  <= 1'b0;
            res_sel_q   <= '0;
            res_xerr_q  <= 1'b0;
            xsticky_q   <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q  <= state_d;
            rdy_en_q <= 1'b1;
            if (beat_acc) begin
                case (state_q)
                    GET_A:   calc_a_q   <= in_data;
                    GET_B:   calc_b_q   <= in_data;
                    default: calc_sel_q <= in_data;
                endcase
            end
            // The non-binary beat flag lives for one transaction only.
            if (state_q != GET_A && state_d == GET_A) begin
                xsticky_q <= 1'b0;
            end else if (beat_acc && $isunknown(in_data)) begin
                xsticky_q <= 1'b1;
            end
            if (clr) begin
                res_valid_q <= 1'b0;
            end else if (capture) begin
                res_valid_q <= 1'b1;
                res_data_q  <= calc_y;
                res_flag_q  <= calc_yrep;
                res_sel_q   <= calc_sel_q;
                res_xerr_q  <= xsticky_q || $isunknown({calc_yrep, calc_y});
            end else if (res_hs) begin
                res_valid_q <= 1'b0;
                op_count_q  <= op_count_q + 1'b1;
            end
        end
    end

    assign calc_a    = calc_a_q;
    assign calc_b    = calc_b_q;
    assign calc_sel  = calc_sel_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_flag  = res_flag_q;
    assign res_sel   = res_sel_q;
    assign res_xerr  = res_xerr_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_calci_op_sequencer.sv
// Directed plus randomized transactions against a behavioural core and result model.
module tb_calci_op_sequencer;

    localparam int S  = 3;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n, clr, in_valid, in_ready, res_valid, res_ready;
    logic [1:0]    in_data, calc_a, calc_b, calc_sel, res_sel;
    logic [3:0]    calc_y, res_data;
    logic          calc_yrep, res_flag, res_xerr;
    logic [CW-1:0] op_count;

    int vectors    = 0;
    int miscompares = 0;
    int exp_count  = 0;

    always #5 clk = ~clk;

    calci_op_sequencer #(.SETTLE_CYCLES(S), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .calc_a    (calc_a),
        .calc_b    (calc_b),
        .calc_sel  (calc_sel),
        .calc_y    (calc_y),
        .calc_yrep (calc_yrep),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_flag  (res_flag),
        .res_sel   (res_sel),
        .res_xerr  (res_xerr),
        .op_count  (op_count)
    );

    // Behavioural calculator core: add, subtract (borrow), multiply, divide (inexact/div0).
    function automatic logic [4:0] core_fn(input logic [1:0] a, input logic [1:0] b,
                                           input logic [1:0] s);
        logic [3:0] y;
        logic       r;
        case (s)
            2'b00: begin y = {2'b00, a} + {2'b00, b}; r = 1'b0; end
            2'b01: begin y = {2'b00, a} - {2'b00, b}; r = (a < b); end
            2'b10: begin y = {2'b00, a} * {2'b00, b}; r = 1'b0; end
            default: begin
                if (b == 2'b00) begin y = 4'd0; r = 1'b1; end
                else begin y = {2'b00, a / b}; r = ((a % b) != 2'b00); end
            end
        endcase
        return {r, y};
    endfunction

    always_comb {calc_yrep, calc_y} = core_fn(calc_a, calc_b, calc_sel);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_beat(input logic [1:0] d, input int gap);
        int t = 0;
        repeat (gap) begin
            in_valid = 1'b0;
            in_data  = 2'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("beat_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic consume(input int stall, input logic [3:0] ed, input bit chk_data);
        repeat (stall) begin
            @(negedge clk);
            chk("stall_valid", 32'(res_valid), 32'd1);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            if (chk_data) chk("stall_data", 32'(res_data), 32'(ed));
        end
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        exp_count = (exp_count + 1) % (1 << CW);
        chk("op_count", 32'(op_count), 32'(exp_count));
        chk("valid_drop", 32'(res_valid), 32'd0);
        chk("in_ready_after", 32'(in_ready), 32'd1);
    endtask

    task automatic run_txn(input logic [1:0] a, input logic [1:0] b, input logic [1:0] s,
                           input int gap, input int stall, input bit chk_data);
        logic [4:0] e;
        logic       xe;
        e  = core_fn(a, b, s);
        xe = $isunknown({a, b, s});
        send_beat(a, gap);
        if (chk_data) chk("calc_a", 32'(calc_a), 32'(a));
        send_beat(b, gap);
        if (chk_data) chk("calc_a_hold", 32'(calc_a), 32'(a));
        if (chk_data) chk("calc_b", 32'(calc_b), 32'(b));
        send_beat(s, gap);
        chk("calc_sel", 32'(calc_sel), 32'(s));
        for (int j = 0; j < S; j++) begin
            chk("latency_low", 32'(res_valid), 32'd0);
            chk("settle_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        chk("latency_high", 32'(res_valid), 32'd1);
        if (chk_data) begin
            chk("res_data", 32'(res_data), 32'(e[3:0]));
            chk("res_flag", 32'(res_flag), 32'(e[4]));
        end
        chk("res_sel", 32'(res_sel), 32'(s));
        chk("res_xerr", 32'(res_xerr), 32'(xe));
        consume(stall, e[3:0], chk_data);
        if (chk_data) chk("calc_a_persist", 32'(calc_a), 32'(a));
    endtask

    initial begin
        logic [1:0] xx;
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = 2'b00; res_ready = 1'b0;
        #3;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_calc", 32'({calc_a, calc_b, calc_sel}), 32'd0);
        chk("rst_res", 32'({res_data, res_flag, res_sel, res_xerr}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rel_in_ready_low", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("rel_in_ready_high", 32'(in_ready), 32'd1);

        run_txn(2'd2, 2'd1, 2'b00, 0, 0, 1'b1);
        run_txn(2'd1, 2'd3, 2'b11, 0, 5, 1'b1);
        run_txn(2'd3, 2'd2, 2'b10, 2, 1, 1'b1);

        // clr during the select beat: select dropped, back to collecting A.
        send_beat(2'd1, 0);
        send_beat(2'd1, 0);
        in_valid = 1'b1; in_data = 2'b01; clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; clr = 1'b0;
        chk("clr_sel_kept", 32'(calc_sel), 32'(2'b10));
        chk("clr_in_ready", 32'(in_ready), 32'd1);
        chk("clr_res_valid", 32'(res_valid), 32'd0);
        chk("clr_op_count", 32'(op_count), 32'(exp_count));
        run_txn(2'd0, 2'd2, 2'b01, 0, 0, 1'b1);

        // clr beats a simultaneous result handshake.
        send_beat(2'd3, 0);
        send_beat(2'd1, 0);
        send_beat(2'b00, 0);
        repeat (S) @(negedge clk);
        chk("hold_valid", 32'(res_valid), 32'd1);
        res_ready = 1'b1; clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0; clr = 1'b0;
        chk("clr_hold_valid", 32'(res_valid), 32'd0);
        chk("clr_hold_count", 32'(op_count), 32'(exp_count));
        chk("clr_hold_in_ready", 32'(in_ready), 32'd1);

        // Asynchronous reset in the middle of SETTLE.
        send_beat(2'd2, 0);
        send_beat(2'd2, 0);
        send_beat(2'b10, 0);
        #2 rst_n = 1'b0;
        #1;
        exp_count = 0;
        chk("arst_valid", 32'(res_valid), 32'd0);
        chk("arst_calc", 32'({calc_a, calc_b, calc_sel}), 32'd0);
        chk("arst_count", 32'(op_count), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_rel_ready", 32'(in_ready), 32'd1);
        run_txn(2'd3, 2'd3, 2'b01, 0, 0, 1'b1);

        // Non-binary operand beat, then a clean transaction.
        xx = 2'bxx;
        run_txn(xx, 2'd1, 2'b00, 0, 0, 1'b0);
        run_txn(2'd1, 2'd1, 2'b00, 0, 0, 1'b1);

        for (int i = 0; i < 10; i++) begin
            run_txn(2'($urandom), 2'($urandom), 2'($urandom),
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
